// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer:
// controller state encoding and operation codes.
package multiword_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/multiword_add_seq_add_slice.sv
// Combinational N-bit adder slice with carry in/out; the only adder in the
// sequencer, reused once per word.
module add_slice #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};

endmodule

// File: rtl/multiword_add_seq.sv
// Time-multiplexes one N-bit adder slice over WORDS cycles to add or subtract
// two N*WORDS-bit operands, rippling the carry through a register between words.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               c_in,
  output logic [N*WORDS-1:0] sum,
  output logic               c_out,
  output logic               busy,
  output logic               done
);

  localparam int            W    = N * WORDS;
  localparam int            IW   = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic [IW-1:0] r_idx;
  logic          r_carry, r_cout;

  logic [N-1:0]  w_x, w_y, w_s;
  logic          w_co, w_last;

  assign w_last = (r_idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves it unset (no latch).
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_x = r_a[r_idx*N +: N];
  assign w_y = r_b[r_idx*N +: N];

  add_slice #(.N(N)) u_slice (
    .x  (w_x),
    .y  (w_y),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_idx <= '0;
            // Subtract is a + ~b + 1, so c_in is overridden.
            case (op)
              OP_SUB: begin
                r_b     <= ~b;
                r_carry <= 1'b1;
              end
              default: begin
                r_b     <= b;
                r_carry <= c_in;
              end
            endcase
          end
        end
        RUN: begin
          r_sum[r_idx*N +: N] <= w_s;
          r_carry             <= w_co;
          if (w_last) r_cout <= w_co;
          else        r_idx  <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomized self-checking bench for multiword_add_seq against a plain
// wide-arithmetic reference model.
module tb_multiword_add_seq;

  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst, start, op, c_in;
  logic [W-1:0] a, b, sum;
  logic         c_out, busy, done;

  int           n_total = 0;
  int           n_bad   = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  always #5 clk = ~clk;

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: {carry/no-borrow, result} from plain 129-bit arithmetic.
  function automatic logic [W:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci);
    logic [W:0] r;
    if (o) r = {(x >= y), x - y};
    else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one operation from IDLE; noise scrambles inputs and pulses start during RUN,
  // chain leaves start high through DONE so the next call is accepted at once.
  task automatic do_op(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input bit noise, input bit chain);
    logic [W:0]   exp;
    logic [W-1:0] mask;
    exp   = model(o, x, y, ci);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    c_in  = ci;
    tick;
    check({tag, "/busy_acc"}, busy, 1);
    check({tag, "/done_acc"}, done, 0);
    for (int k = 1; k <= WORDS; k++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        op   = 1'($urandom_range(0, 1));
        a    = rnd_w();
        b    = rnd_w();
        c_in = 1'($urandom_range(0, 1));
      end
      tick;
      mask = (k == WORDS) ? '1 : ((W'(1) << (k * N)) - W'(1));
      check({tag, "/sum_prog"}, sum, (exp[W-1:0] & mask) | (prev_sum & ~mask));
      if (k < WORDS) begin
        check({tag, "/busy_run"}, busy, 1);
        check({tag, "/done_run"}, done, 0);
        check({tag, "/cout_hold"}, c_out, prev_cout);
      end else begin
        check({tag, "/busy_done"}, busy, 0);
        check({tag, "/done_pulse"}, done, 1);
        check({tag, "/cout"}, c_out, exp[W]);
      end
    end
    start = chain;
    tick;
    check({tag, "/done_off"}, done, 0);
    check({tag, "/busy_off"}, busy, 0);
    check({tag, "/sum_hold"}, sum, exp[W-1:0]);
    prev_sum  = exp[W-1:0];
    prev_cout = exp[W];
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; c_in = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;

    tick;
    tick;
    check("rst_sum", sum, 0);
    check("rst_cout", c_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    start = 1'b1; a = rnd_w(); b = rnd_w();
    tick;
    check("rst_start_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    tick;
    check("rst_start_busy2", busy, 0);
    check("rst_start_done", done, 0);

    do_op("ripple", 1'b0, '1, W'(1), 1'b0, 1'b0, 1'b0);
    do_op("xword", 1'b0, {32'h0, {96{1'b1}}}, '0, 1'b1, 1'b0, 1'b0);
    do_op("sub75_c0", 1'b1, W'(7), W'(5), 1'b0, 1'b0, 1'b0);
    do_op("sub75_c1", 1'b1, W'(7), W'(5), 1'b1, 1'b0, 1'b0);
    do_op("sub57", 1'b1, W'(5), W'(7), 1'b0, 1'b0, 1'b0);
    do_op("sub57_c1", 1'b1, W'(5), W'(7), 1'b1, 1'b0, 1'b0);

    do_op("busyprot", 1'b0, W'(1), W'(2), 1'b0, 1'b1, 1'b0);
    repeat (2) begin
      tick;
      check("busyprot_nodone", done, 0);
    end

    do_op("chain_a", 1'b0, rnd_w(), rnd_w(), 1'b1, 1'b0, 1'b1);
    do_op("chain_b", 1'b1, rnd_w(), rnd_w(), 1'b0, 1'b0, 1'b0);

    start = 1'b1; op = 1'b0; a = rnd_w(); b = rnd_w(); c_in = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_sum", sum, 0);
    check("midrst_cout", c_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    repeat (WORDS + 1) begin
      tick;
      check("midrst_nodone", done, 0);
      check("midrst_idle", busy, 0);
    end
    prev_sum  = '0;
    prev_cout = 1'b0;
    do_op("after_rst", 1'b0, W'(10), W'(20), 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), rnd_w(), rnd_w(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), (i < 15) && ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that performs WORDS×N-bit add or subtract by time-multiplexing a single N-bit adder slice over WORDS cycles. It walks the operands least-significant word first and feeds each word's carry-out into the next word's carry-in. Operands are captured on a start handshake, and the full-width result is presented with a one-cycle done pulse. It sits beside the N-bit adder datapath as its controller, giving wide arithmetic without a wide carry chain.

## Interface
- N, 32, adder slice width in bits
- WORDS, 4, number of N-bit words per operand (≥2); operand width W = N*WORDS
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add (a+b+c_in), 1 = subtract (a−b); sampled with start
- a  input  W  operand A; sampled with start
- b  input  W  operand B; sampled with start
- c_in  input  1  carry into word 0 for add; ignored for subtract
- sum  output  W  result register
- c_out  output  1  carry out of top word; for subtract, 1 = no borrow (a ≥ b unsigned)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; sum/c_out valid

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch a, b_eff, carry, and op; clear word index idx to 0; go to RUN. Otherwise stay.
  - b_eff = op ? ~b : b.
  - carry = op ? 1 : c_in.
- RUN, each cycle:
  - Drive the slice with a_reg[idx], b_reg[idx] and carry.
  - Write the slice sum into sum[idx*N +: N] and the slice carry-out into carry.
  - If idx == WORDS−1, go to DONE and set c_out to the slice carry-out. Otherwise idx++.
- DONE: done=1 for exactly one cycle, then IDLE.
- sum and c_out hold their values until the next accepted start.
  - On acceptance, sum words are overwritten progressively during RUN.
  - c_out is updated only at the DONE transition.
- start is ignored in RUN and DONE, with no queuing. Operand or op changes after acceptance have no effect on the result.
- Arithmetic is modulo 2^W. No signed overflow flag.
- Reset, including mid-RUN: state=IDLE, idx=0, carry=0, sum=0, c_out=0, busy=0, done=0. Any partial result is discarded.
- Simultaneous rst and start: rst wins and start is dropped.

## Timing
- Let start=1 be sampled in IDLE at edge t.
- busy is high from after edge t until after edge t+WORDS.
- Word k is written at edge t+1+k.
- done is high during the cycle after edge t+WORDS (default: 4 cycles after the accepting edge), and low after edge t+WORDS+1.
- Earliest next accept is edge t+WORDS+2; throughput is one operation per WORDS+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The slice is combinational. Critical path: operand-word mux → N-bit add → sum/carry registers.

## Structure
- Shared package holds:
  - FSM state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Op codes: OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module add_slice (parameter N): combinational {co, s} = x + y + ci. It is the only adder instance.
- idx width is $clog2(WORDS).
- Word select uses indexed part-select on the latched operand registers.

## Test plan
All scenarios use defaults N=32, WORDS=4 (W=128).
- Reset: hold rst 2 cycles → sum=0, c_out=0, busy=0, done=0. Assert start with rst=1 → no RUN entry.
- Full ripple: add, a=all ones, b=1, c_in=0 → sum=0, c_out=1, done 4 cycles after the accepting edge, busy high for exactly 4 cycles.
- Cross-word carry: add, a=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=0, c_in=1 → sum=0x00000001_00000000_00000000_00000000, c_out=0.
- Subtract:
  - a=7, b=5 → sum=2, c_out=1.
  - a=5, b=7 → sum=0xFFFF…FFFE (128-bit), c_out=0.
  - c_in=0 vs c_in=1 gives an identical result.
- Busy protection: accept add 1+2. During RUN, pulse start with a=0xDEAD, b=0xBEEF, op=1 → result 3, c_out=0, no second done. Start held high through DONE→IDLE is accepted on the first IDLE edge.
- Mid-run reset: assert rst when idx=2 → next cycle all outputs 0, state IDLE, no done. A following add of 10+20 yields 30 normally.
